// File: rtl/lsu.sv
// lsu -- load/store unit for the MEM stage of an RV32I pipeline.
//
// Accepts one load or store from the EX/MEM slot and issues it on a
// req/gnt/rvalid data-memory port. Word-aligned address, byte enables and
// lane-replicated store data are registered. Returned load data is
// aligned, extended and registered for write-back. stall_n holds the
// pipeline for the whole access.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid/read/write      EX/MEM slot control (read wins over write)
//   ex_funct3, ex_addr       access size/signedness and byte address
//   ex_wdata, ex_rd          store data and load destination
//   stall_n                  low = freeze PC, IF/ID, ID/EX, EX/MEM
//   wb_valid, wb_rd, wb_data registered load result (one-cycle pulse)
//   err                      one-cycle pulse: misaligned/illegal/timeout
//   mem_*                    data-memory request/response port
//
// Optional feature: define LSU_TIMEOUT_EN to add a watchdog that aborts an
// access after TIMEOUT_CYCLES cycles in REQ/RESP.
module lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_read,
    input  logic                  ex_write,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [WORD_WIDTH-1:0] ex_wdata,
    input  logic [4:0]            ex_rd,
    output logic                  stall_n,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [WORD_WIDTH-1:0] wb_data,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                  state_q;
    logic                    mem_req_q, mem_we_q, wb_valid_q, err_q;
    logic [2:0]              funct3_q;
    logic [1:0]              off_q;
    logic [4:0]              rd_q, wb_rd_q;
    logic [3:0]              be_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WORD_WIDTH-1:0]   wdata_q, wb_data_q, wb_data_d;
    logic                    start, f3_ok, misalign, legal, timeout;

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    always_comb begin
        start = ex_valid & (ex_read | ex_write);
        // Loads additionally allow the unsigned byte/half encodings.
        if (ex_read)
            f3_ok = (ex_funct3[1:0] != 2'b11) && !(ex_funct3[2] && ex_funct3[1]);
        else
            f3_ok = !ex_funct3[2] && (ex_funct3[1:0] != 2'b11);
        case (ex_funct3[1:0])
            2'b01:   misalign = ex_addr[0];
            2'b10:   misalign = (ex_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
        legal     = f3_ok & ~misalign;
        wb_data_d = extract_load(funct3_q, off_q, mem_rdata);
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Held at zero in IDLE, so it starts from zero on every REQ entry.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(1);
    end

    // A store grant or a load response in the limit cycle still completes normally.
    assign timeout = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                     && !(state_q == REQ  && mem_gnt && mem_we_q)
                     && !(state_q == RESP && mem_rvalid);
`else
    assign timeout = 1'b0;
`endif

    // The completion cycle (store grant, load rvalid) releases the stall so
    // the pipeline advances on the same edge that returns us to IDLE.
    assign stall_n = rst | ~(((state_q == IDLE) & start & legal) |
                             ((state_q == REQ)  & ~(mem_gnt & mem_we_q) & ~timeout) |
                             ((state_q == RESP) & ~mem_rvalid & ~timeout));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            be_q       <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            mem_we_q  <= ~ex_read;
                            funct3_q  <= ex_funct3;
                            off_q     <= ex_addr[1:0];
                            rd_q      <= ex_rd;
                            be_q      <= byte_enables(ex_funct3[1:0], ex_addr[1:0]);
                            addr_q    <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                            wdata_q   <= replicate(ex_funct3[1:0], ex_wdata);
                            mem_req_q <= 1'b1;
                            state_q   <= REQ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (timeout) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= IDLE;
                    end else if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_we_q ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (mem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= wb_data_d;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_read, ex_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall_n, wb_valid, err, mem_req, mem_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;

    int checks = 0;
    int errors = 0;

    lsu #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_read(ex_read), .ex_write(ex_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall_n(stall_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          g;          // cycles before gnt
        int          r;          // extra RESP cycles before rvalid
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;  // checked for stores only
        logic [31:0] exp_wb;     // checked for loads only
        int          exp_stall;  // cycles with stall_n low
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int    stalls;
        string tag;
        tag = $sformatf("v%0d", idx);
        stalls = 0;
        ex_valid = 1'b1; ex_read = v.rd_op; ex_write = v.wr_op; ex_funct3 = v.f3;
        ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
        #1;
        if (!stall_n) stalls++;
        step();
        // Scramble the EX/MEM inputs: they must not matter after acceptance.
        ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0; ex_funct3 = 3'b111;
        ex_addr = ~v.addr; ex_wdata = ~v.wdata; ex_rd = ~v.rd;
        if (v.exp_err) begin
            check({tag, " err"}, {31'd0, err}, 32'd1);
            check({tag, " no_req"}, {31'd0, mem_req}, 32'd0);
            step();
            check({tag, " err_pulse"}, {31'd0, err}, 32'd0);
        end else begin
            check({tag, " req"}, {31'd0, mem_req}, 32'd1);
            check({tag, " we"}, {31'd0, mem_we}, {31'd0, ~v.rd_op});
            check({tag, " be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
            for (int i = 0; i < v.g; i++) begin
                mem_gnt = 1'b0;
                #1;
                if (!stall_n) stalls++;
                step();
            end
            check({tag, " addr"}, mem_addr, v.exp_addr);
            check({tag, " req_held"}, {31'd0, mem_req}, 32'd1);
            if (!v.rd_op) check({tag, " wdata"}, mem_wdata, v.exp_wdata);
            mem_gnt = 1'b1;
            #1;
            if (!stall_n) stalls++;
            step();
            mem_gnt = 1'b0;
            check({tag, " req_drop"}, {31'd0, mem_req}, 32'd0);
            if (v.rd_op) begin
                for (int i = 0; i < v.r; i++) begin
                    #1;
                    if (!stall_n) stalls++;
                    step();
                end
                mem_rvalid = 1'b1; mem_rdata = v.rdata;
                #1;
                if (!stall_n) stalls++;
                step();
                mem_rvalid = 1'b0; mem_rdata = 32'h0;
                check({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
                check({tag, " wb_data"}, wb_data, v.exp_wb);
                check({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
                step();
                check({tag, " wb_pulse"}, {31'd0, wb_valid}, 32'd0);
            end else begin
                check({tag, " no_wb"}, {31'd0, wb_valid}, 32'd0);
            end
        end
        check({tag, " stall_cycles"}, stalls, v.exp_stall);
    endtask

    initial begin
        //              rd   wr  f3      addr          wdata         rd     rdata         g  r  err  exp_addr      be       exp_wdata     exp_wb        stall
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd5,  32'hDEADBEEF, 2, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEADBEEF, 4};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd7,  32'h80FFFF00, 0, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFFFF80, 2};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd8,  32'h80FFFF00, 0, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h00000080, 2};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        5'd9,  32'h80FFFF00, 0, 0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'h000080FF, 2};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd10, 32'h80FFFF00, 0, 0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF80FF, 2};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        5'd11, 32'h12345678, 1, 0, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,        32'h00000056, 3};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h1234ABCD, 5'd0,  32'h0,        0, 0, 1'b0, 32'h0000_0204, 4'b1100, 32'hABCDABCD, 32'h0,        1};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h000000A5, 5'd0,  32'h0,        1, 0, 1'b0, 32'h0000_0300, 4'b0010, 32'hA5A5A5A5, 32'h0,        2};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_040C, 32'hCAFEF00D, 5'd0,  32'h0,        0, 0, 1'b0, 32'h0000_040C, 4'b1111, 32'hCAFEF00D, 32'h0,        1};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        5'd3,  32'h0,        0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        5'd3,  32'h0,        0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        0};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_0201, 32'h0,        5'd0,  32'h0,        0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        0};
        vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'h0,        5'd0,  32'h0,        0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        0};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,        5'd31, 32'h0BADF00D, 1, 2, 1'b0, 32'h0000_0500, 4'b1111, 32'h0,        32'h0BADF00D, 5};
        vecs[14] = '{1'b1, 1'b1, 3'b000, 32'h0000_0102, 32'h0,        5'd12, 32'h00FE0000, 0, 0, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,        32'hFFFFFFFE, 2};

        rst = 1'b1;
        ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0; ex_funct3 = 3'b000;
        ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step();
        step();
        check("rst mem_req",  {31'd0, mem_req},  32'd0);
        check("rst mem_we",   {31'd0, mem_we},   32'd0);
        check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst err",      {31'd0, err},      32'd0);
        check("rst mem_be",   {28'd0, mem_be},   32'd0);
        check("rst mem_addr", mem_addr,          32'd0);
        check("rst mem_wdata", mem_wdata,        32'd0);
        check("rst wb_data",  wb_data,           32'd0);
        check("rst wb_rd",    {27'd0, wb_rd},    32'd0);
        check("rst stall_n",  {31'd0, stall_n},  32'd1);
        rst = 1'b0;
        // rvalid in IDLE must be ignored
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        step();
        mem_rvalid = 1'b0;
        check("idle rvalid ignored", {31'd0, wb_valid}, 32'd0);

        for (int i = 0; i < 15; i++) run_txn(vecs[i], i);

        // Reset while waiting in RESP, then a stale rvalid.
        ex_valid = 1'b1; ex_read = 1'b1; ex_write = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0600; ex_rd = 5'd4;
        step();
        ex_valid = 1'b0; ex_read = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        #1;
        check("resp stall", {31'd0, stall_n}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        #1;
        check("post-rst stall_n", {31'd0, stall_n}, 32'd1);
        step();
        mem_rvalid = 1'b0;
        check("post-rst no wb_valid", {31'd0, wb_valid}, 32'd0);
        check("post-rst mem_req", {31'd0, mem_req}, 32'd0);
        step();
        check("post-rst wb quiet", {31'd0, wb_valid}, 32'd0);
        // Back in IDLE: a fresh load works normally.
        run_txn(vecs[0], 100);

`ifdef LSU_TIMEOUT_EN
        // Store whose grant never arrives: abort after 8 cycles in REQ.
        ex_valid = 1'b1; ex_read = 1'b0; ex_write = 1'b1; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0700; ex_wdata = 32'h11112222;
        step();
        ex_valid = 1'b0; ex_write = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("to stall c%0d", i), {31'd0, stall_n}, 32'd0);
            step();
        end
        #1;
        check("to stall release", {31'd0, stall_n}, 32'd1);
        check("to req before", {31'd0, mem_req}, 32'd1);
        step();
        check("to err", {31'd0, err}, 32'd1);
        check("to req drop", {31'd0, mem_req}, 32'd0);
        check("to no wb", {31'd0, wb_valid}, 32'd0);
        step();
        check("to err pulse", {31'd0, err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
